// File: rtl/ysyx_22051468_inst_fetch.sv
// ysyx_22051468_inst_fetch: PC register and fetch FSM feeding instruction decode.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   ibus_req_valid_o/ready_i request handshake, ibus_addr_o is the PC
//   ibus_rsp_valid_i/data_i  valid-only read response, in order
//   redirect_i/redirect_pc_i PC redirect from execute, highest priority
//   inst_valid_o/ready_i     decode handshake
//   inst_o, inst_addr_o      registered instruction word and its PC
//   inst_misalign_o          only when IFU_MISALIGN_CHECK_EN is defined
//
// Build option: IFU_MISALIGN_CHECK_EN turns misaligned redirect targets into
// an ebreak presented to decode instead of a fetch; without it the low two
// target bits are cleared.
module ysyx_22051468_inst_fetch #(
    parameter int unsigned      WIDTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(64'h8000_0000)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ibus_req_valid_o,
    input  logic             ibus_req_ready_i,
    output logic [WIDTH-1:0] ibus_addr_o,
    input  logic             ibus_rsp_valid_i,
    input  logic [31:0]      ibus_rsp_data_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             inst_valid_o,
    input  logic             inst_ready_i,
    output logic [31:0]      inst_o,
    output logic [WIDTH-1:0] inst_addr_o
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic             inst_misalign_o
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] inst_addr_q, inst_addr_d;
    logic [31:0]      inst_q, inst_d;
    logic             drop_q, drop_d;
    logic [WIDTH-1:0] target;
    logic             outstanding;

`ifdef IFU_MISALIGN_CHECK_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    logic misalign_q, misalign_d;
    assign target          = redirect_pc_i;
    assign inst_misalign_o = misalign_q;
`else
    assign target = redirect_pc_i & ~WIDTH'(3);
`endif

    assign ibus_req_valid_o = state_q == REQ;
    assign ibus_addr_o      = pc_q;
    assign inst_valid_o     = state_q == HOLD;
    assign inst_o           = inst_q;
    assign inst_addr_o      = inst_addr_q;

    // A request is in flight past this edge if it is accepted now or was
    // accepted earlier and its response has not arrived yet.
    assign outstanding = (state_q == REQ && ibus_req_ready_i) ||
                         (state_q == WAIT && !ibus_rsp_valid_i);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
`ifdef IFU_MISALIGN_CHECK_EN
        misalign_d  = misalign_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                state_d = ibus_req_ready_i ? WAIT : REQ;
                drop_d  = drop_q && !ibus_rsp_valid_i;
            end
            WAIT: begin
                if (ibus_rsp_valid_i && drop_q) begin
                    drop_d  = 1'b0;
                    state_d = REQ;
                end else if (ibus_rsp_valid_i) begin
                    inst_d      = ibus_rsp_data_i;
                    inst_addr_d = pc_q;
                    state_d     = HOLD;
`ifdef IFU_MISALIGN_CHECK_EN
                    misalign_d  = 1'b0;
`endif
                end
            end
            HOLD: begin
                pc_d    = inst_ready_i ? pc_q + WIDTH'(4) : pc_q;
                state_d = inst_ready_i ? REQ : HOLD;
                drop_d  = drop_q && !ibus_rsp_valid_i;
            end
            default: state_d = IDLE;
        endcase
        // Redirect overrides whatever the state machine decided above; any
        // request still in flight is marked so its response is discarded.
        if (redirect_i) begin
            pc_d    = target;
            state_d = outstanding ? WAIT : REQ;
            drop_d  = drop_d || outstanding;
`ifdef IFU_MISALIGN_CHECK_EN
            if (|redirect_pc_i[1:0]) begin
                state_d     = HOLD;
                inst_d      = EBREAK;
                inst_addr_d = redirect_pc_i;
                misalign_d  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            inst_q      <= '0;
            inst_addr_q <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
`ifdef IFU_MISALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end
endmodule
